// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes and FSM state encoding for alu_seq.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: WIDTH-iteration shift-add multiplier, one partial product per clock.
// Operands latch on start; done pulses during the final iteration and product
// then carries the completed result, so the consumer can register it on that edge.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
  assign busy       = r_busy;
  assign done       = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  assign product    = w_acc_next;

  // Iteration control: busy flag and counter, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start && !r_busy) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Datapath: accumulate one shifted multiplicand per iteration
  always_ff @(posedge clk) begin
    if (start && !r_busy) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, A};
      r_mplier <= B;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result, carry and zero.
// Build option ALU_MUL_EN: when defined, sel = 111 runs the iterative
// multiplier (WIDTH cycles); when undefined it completes in one cycle with
// Y = 0, carry = 1 and no multiplier or MUL state is built.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [OP_W-1:0]   sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  Y,
  output logic              carry,
  output logic              zero
);

  localparam int SH_W = $clog2(WIDTH);

  // Single-cycle result packed as {carry, y}
  function automatic logic [WIDTH:0] alu_op(input op_e op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0]  t;
    logic [WIDTH:0]  s;
    logic [SH_W-1:0] n;
    t = '0;
    s = '0;
    n = b[SH_W-1:0];
    case (op)
      OP_ADD: t = {1'b0, a} + {1'b0, b};
      OP_SUB: t = {(a < b), a - b};
      OP_AND: t = {1'b0, a & b};
      OP_OR:  t = {1'b0, a | b};
      OP_XOR: t = {1'b0, a ^ b};
      // Bit WIDTH of the widened shift is the last bit pushed out (0 when n = 0)
      OP_SHL: t = {1'b0, a} << n;
      // A guard zero below bit 0 catches the last bit shifted out
      OP_SHR: begin
        s = {a, 1'b0} >> n;
        t = {s[0], s[WIDTH:1]};
      end
      default: t = {1'b1, {WIDTH{1'b0}}};
    endcase
    return t;
  endfunction

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_y;
  logic              r_carry;
  logic              r_zero;
  logic              w_accept;
  logic              w_load;
  logic [WIDTH:0]    w_alu;
  logic [WIDTH:0]    w_res;

  assign w_accept = in_valid && in_ready;
  assign w_alu    = alu_op(op_e'(sel), A, B);

`ifdef ALU_MUL_EN
  state_e              r_state;
  logic                w_is_mul;
  logic                w_mul_busy;
  logic                w_mul_done;
  logic [2*WIDTH-1:0]  w_prod;

  assign w_is_mul = (op_e'(sel) == OP_MUL);
  assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready) && !rst;
  assign w_load   = (w_accept && !w_is_mul) || w_mul_done;
  assign w_res    = w_mul_done ? {|w_prod[2*WIDTH-1:WIDTH], w_prod[WIDTH-1:0]} : w_alu;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_accept && w_is_mul),
    .A       (A),
    .B       (B),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_prod)
  );

  // Sequencer: park in ST_MUL until the multiplier hands back its result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept && w_is_mul) r_state <= ST_MUL;
        ST_MUL:  if (w_mul_done || !w_mul_busy) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`else
  assign in_ready = (!r_out_valid || out_ready) && !rst;
  assign w_load   = w_accept;
  assign w_res    = w_alu;
`endif

  // Output register: load on completion, drop valid on drain without reload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_y         <= w_res[WIDTH-1:0];
      r_carry     <= w_res[WIDTH];
      r_zero      <= (w_res[WIDTH-1:0] == '0);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign Y         = r_y;
  assign carry     = r_carry;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH = 8).
module tb_alu_seq;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [2:0]    sel;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Y;
  logic          carry;
  logic          zero;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .carry     (carry),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: {Y, carry, zero} from plain integer arithmetic
  function automatic logic [9:0] model(input int a, input int b, input int s);
    int y, c, n, p;
    n = b % W;
    y = 0;
    c = 0;
    case (s)
      0: begin p = a + b; y = p % 256; c = (p > 255) ? 1 : 0; end
      1: begin y = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: begin y = (a * (2 ** n)) % 256; c = (n == 0) ? 0 : (a / (2 ** (W - n))) % 2; end
      6: begin y = a / (2 ** n); c = (n == 0) ? 0 : (a / (2 ** (n - 1))) % 2; end
      default: begin
`ifdef ALU_MUL_EN
        p = a * b; y = p % 256; c = ((p / 256) != 0) ? 1 : 0;
`else
        y = 0; c = 1;
`endif
      end
    endcase
    return {y[7:0], c[0], (y == 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int a, input int b, input int s);
    in_valid = 1'b1;
    A   = W'(a);
    B   = W'(b);
    sel = 3'(s);
    tick();
    in_valid = 1'b0;
    A   = W'($urandom);
    B   = W'($urandom);
    sel = 3'($urandom);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] y, input logic c, input logic z);
    check(tag, 32'({out_valid, Y, carry, zero}), 32'({1'b1, y, c, z}));
  endtask

  typedef logic [9:0] res_t;
  res_t       q[$];
  res_t       exp_r;
  logic [9:0] hold_v;
  bit         holding;
  bit         stale;
  int         k;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; sel = '0;
    tick(); tick();
    check("reset_state", 32'({out_valid, Y, carry, zero}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    issue(200, 100, 0);  check_res("add_200_100", 8'd44, 1'b1, 1'b0);
    issue(3, 5, 1);      check_res("sub_3_5", 8'hFE, 1'b1, 1'b0);
    issue(5, 5, 1);      check_res("sub_5_5", 8'h00, 1'b0, 1'b1);
    issue(8'h81, 1, 5);  check_res("shl_81_1", 8'h02, 1'b1, 1'b0);
    issue(8'h81, 0, 6);  check_res("shr_81_0", 8'h81, 1'b0, 1'b0);

    issue(15, 17, 7);
`ifdef ALU_MUL_EN
    for (int i = 0; i < W; i++) begin
      check("mul_busy", 32'({in_ready, out_valid}), 32'd0);
      tick();
    end
    check_res("mul_15_17", 8'hFF, 1'b0, 1'b0);
    check("mul_done_in_ready", 32'(in_ready), 32'd1);
`else
    check_res("mul_off_15_17", 8'h00, 1'b1, 1'b1);
`endif

    issue(16, 16, 7);
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check_res("mul_16_16", 8'h00, 1'b1, 1'b1);
    tick();

    // Backpressure: second op waits, result held, then drain+load on one edge
    out_ready = 1'b0;
    in_valid = 1'b1; A = 8'd1; B = 8'd1; sel = 3'd0;
    #1;
    check("bp_first_ready", 32'(in_ready), 32'd1);
    tick();
    A = 8'hF0; B = 8'h0F; sel = 3'd4;
    #1;
    check_res("bp_add_held0", 8'h02, 1'b0, 1'b0);
    check("bp_blocked0", 32'(in_ready), 32'd0);
    tick();
    check_res("bp_add_held1", 8'h02, 1'b0, 1'b0);
    check("bp_blocked1", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_drain_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_res("bp_xor", 8'hFF, 1'b0, 1'b0);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Reset three cycles into a multiply
    issue(255, 255, 7);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("midmul_reset_out", 32'({out_valid, Y, carry, zero}), 32'd0);
    check("midmul_reset_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("midmul_release_ready", 32'(in_ready), 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    check("midmul_no_stale", 32'(stale), 32'd0);

    // Randomized traffic against the scoreboard
    holding = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      A         = W'($urandom);
      B         = W'($urandom);
      sel       = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (holding) check("rand_hold", 32'({out_valid, Y, carry, zero}), 32'({1'b1, hold_v}));
      if (out_valid && out_ready) begin
        check("rand_expected_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_r = q.pop_front();
          check("rand_result", 32'({Y, carry, zero}), 32'(exp_r));
        end
      end
      holding = out_valid && !out_ready;
      hold_v  = {Y, carry, zero};
      if (in_valid && in_ready) q.push_back(model(int'(A), int'(B), int'(sel)));
      tick();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      #1;
      if (out_valid) begin
        exp_r = q.pop_front();
        check("drain_result", 32'({Y, carry, zero}), 32'(exp_r));
      end
      tick();
      k++;
    end
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    tick();
    check("drain_out_idle", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 4-bit combinational ALU. It takes WIDTH-bit operands and an op select through a valid/ready input channel and returns a registered result with carry and zero flags through a valid/ready output channel. Single-cycle ops sustain one result per clock. MUL runs as a WIDTH-cycle iterative shift-add. The block sits between an operand source (sequencer or register file) and a result sink that may apply backpressure.

## Interface
- WIDTH, 8: operand/result width, ≥ 2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block accepts this cycle
- A  in  WIDTH  operand A (unsigned)
- B  in  WIDTH  operand B (unsigned); shift amount for SHL/SHR
- sel  in  3  op select
- out_valid  out  1  result held
- out_ready  in  1  sink accepts result
- Y  out  WIDTH  result
- carry  out  1  op-dependent flag (see Operation)
- zero  out  1  Y == 0

## Operation
- Op codes:
  - 000 ADD: Y = A+B; carry = carry-out.
  - 001 SUB: Y = A−B mod 2^WIDTH; carry = borrow (A<B).
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 SHL, 110 SHR: logical shift by n = B[$clog2(WIDTH)-1:0]; carry = last bit shifted out; n = 0 gives carry = 0.
  - 111 MUL: Y = low WIDTH bits of A*B; carry = OR of high WIDTH bits.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst.
- FSM states:
  - IDLE → MUL on accept with sel = 111; other accepted ops stay in IDLE and load the result register.
  - MUL: iterate WIDTH cycles, then load the result register → IDLE.
- Output register: loaded on completion; cleared of valid when out_valid && out_ready with no new load in the same edge. A simultaneous drain and load keeps out_valid = 1 with the new data.
- While out_valid && !out_ready: Y, carry and zero are held stable.
- Inputs are sampled only at accept; A, B and sel may change afterwards.
- Reset, including mid-MUL: state → IDLE, iteration counter → 0, out_valid = 0, Y = 0, carry = 0, zero = 0. The in-flight MUL is discarded and no result is produced.

## Timing
- Single-cycle ops: accepted at edge N → out_valid = 1 after edge N; throughput 1/cycle with out_ready = 1.
- MUL: accepted at edge N → out_valid = 1 after edge N+WIDTH; in_ready = 0 for those WIDTH cycles.
- MUL completion never collides with an undrained result, because acceptance required an empty or draining output register.
- in_ready is combinational from registered state and out_ready. It has no path from in_valid.

## Configuration
- ALU_MUL_EN defined: MUL behaves as above; sub-module instantiated.
- ALU_MUL_EN undefined: sel = 111 completes as a single-cycle op with Y = 0, carry = 1, zero = 1. The MUL state and multiplier are not built.

## Structure
- alu_pkg holds:
  - op enum (OP_ADD … OP_MUL), OP_W = 3
  - FSM state enum (ST_IDLE, ST_MUL)
- Sub-module alu_mul_iter (only under ALU_MUL_EN):
  - ports: start, A, B; busy, done (1 cycle), product[2*WIDTH-1:0]
  - internal WIDTH-iteration shift-add with a $clog2(WIDTH+1)-bit counter
  - asynchronous reset on rst

## Test plan (WIDTH = 8)
- ADD A = 200, B = 100, out_ready = 1 → next cycle Y = 44, carry = 1, zero = 0.
- SUB A = 3, B = 5 → Y = 0xFE, carry = 1; then SUB A = 5, B = 5 → Y = 0, carry = 0, zero = 1.
- SHL A = 0x81, B = 1 → Y = 0x02, carry = 1; SHR A = 0x81, B = 0 → Y = 0x81, carry = 0.
- MUL A = 15, B = 17 → in_ready low 8 cycles, then Y = 0xFF, carry = 0. MUL A = 16, B = 16 → Y = 0, carry = 1, zero = 1. With ALU_MUL_EN undefined, either MUL completes next cycle with Y = 0, carry = 1.
- Backpressure: out_ready = 0, issue ADD 1+1 then XOR 0xF0^0x0F → second op not accepted, Y = 2 held. Raise out_ready → XOR accepted on the drain edge, Y = 0xFF next cycle with no bubble.
- Assert rst 3 cycles into MUL A = 255, B = 255 → out_valid, Y, carry and zero all 0. After release, in_ready = 1 and no stale result appears.
